wb_commit_unit: RTL and testbench

- Writeback/commit stage that sits directly upstream of the CSR file in the five-stage LoongArch pipeline.
- Registers the MEM→WB bundle and arbitrates interrupt, carried exception, ertn and normal commit.
- Produces the CSR exception/ertn strobes, the CSR and GPR write ports, and the front-end redirect.
- Uses a flush epoch so that wrong-path instructions already in flight are discarded.

---
 rtl/wb_commit_unit.sv | 177 +++++++++++++++++
 tb/tb_wb_commit_unit.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/wb_commit_unit.sv
// Writeback/commit stage: registers the MEM bundle, arbitrates interrupt/exception/ertn/commit,
// and drives CSR/GPR writes plus the front-end redirect. Optional trace ports under WB_DEBUG_TRACE_EN.
module wb_commit_unit #(
    parameter logic [5:0] ECODE_INT = 6'h00,
    parameter int         EPOCH_W   = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               ms_to_ws_valid,
    output logic               ws_allow_in,
    input  logic [31:0]        ms_pc,
    input  logic               ms_exc,
    input  logic [5:0]         ms_ecode,
    input  logic [8:0]         ms_esubcode,
    input  logic [31:0]        ms_vaddr,
    input  logic               ms_ertn,
    input  logic [EPOCH_W-1:0] ms_epoch,
    input  logic               ms_rf_we,
    input  logic [4:0]         ms_rf_waddr,
    input  logic [31:0]        ms_rf_wdata,
    input  logic               ms_csr_we,
    input  logic [13:0]        ms_csr_num,
    input  logic [31:0]        ms_csr_wvalue,
    input  logic [31:0]        ms_csr_wmask,
    input  logic               has_int,
    input  logic [31:0]        csr_eentry,
    input  logic [31:0]        csr_era,
    output logic               wb_ex,
    output logic [5:0]         wb_ecode,
    output logic [8:0]         wb_esubcode,
    output logic [31:0]        wb_pc,
    output logic [31:0]        wb_vaddr,
    output logic               ertn_flush,
    output logic               csr_we,
    output logic [13:0]        csr_num,
    output logic [31:0]        csr_wvalue,
    output logic [31:0]        csr_wmask,
    output logic               rf_we,
    output logic [4:0]         rf_waddr,
    output logic [31:0]        rf_wdata,
    output logic [EPOCH_W-1:0] ws_epoch,
    output logic               redirect_valid,
    output logic [31:0]        redirect_pc,
`ifdef WB_DEBUG_TRACE_EN
    output logic [31:0]        debug_wb_pc,
    output logic [3:0]         debug_wb_rf_we,
    output logic [4:0]         debug_wb_rf_wnum,
    output logic [31:0]        debug_wb_rf_wdata,
`endif
    input  logic               redirect_ready
);

    typedef enum logic {RUN = 1'b0, REDIR = 1'b1} state_t;

    state_t             state_q;
    logic [EPOCH_W-1:0] ws_epoch_q;
    logic [31:0]        redirect_pc_q;

    logic               ws_valid_q, ws_valid_d;
    logic [31:0]        ws_pc_q;
    logic               ws_exc_q;
    logic [5:0]         ws_ecode_q;
    logic [8:0]         ws_esubcode_q;
    logic [31:0]        ws_vaddr_q;
    logic               ws_ertn_q;
    logic               ws_rf_we_q;
    logic [4:0]         ws_rf_waddr_q;
    logic [31:0]        ws_rf_wdata_q;
    logic               ws_csr_we_q;
    logic [13:0]        ws_csr_num_q;
    logic [31:0]        ws_csr_wvalue_q;
    logic [31:0]        ws_csr_wmask_q;

    logic commit_act, take_int, take_exc, take_ertn, normal;

    assign ws_allow_in = 1'b1;

    // Wrong-path bundles (stale epoch, or anything arriving during a redirect) never become valid.
    assign ws_valid_d = ms_to_ws_valid && (state_q == RUN) && (ms_epoch == ws_epoch_q);

    always_ff @(posedge clk) begin
        if (reset) begin
            ws_valid_q      <= 1'b0;
            ws_pc_q         <= '0;
            ws_exc_q        <= 1'b0;
            ws_ecode_q      <= '0;
            ws_esubcode_q   <= '0;
            ws_vaddr_q      <= '0;
            ws_ertn_q       <= 1'b0;
            ws_rf_we_q      <= 1'b0;
            ws_rf_waddr_q   <= '0;
            ws_rf_wdata_q   <= '0;
            ws_csr_we_q     <= 1'b0;
            ws_csr_num_q    <= '0;
            ws_csr_wvalue_q <= '0;
            ws_csr_wmask_q  <= '0;
        end else begin
            ws_valid_q <= ws_valid_d;
            if (ms_to_ws_valid) begin
                ws_pc_q         <= ms_pc;
                ws_exc_q        <= ms_exc;
                ws_ecode_q      <= ms_ecode;
                ws_esubcode_q   <= ms_esubcode;
                ws_vaddr_q      <= ms_vaddr;
                ws_ertn_q       <= ms_ertn;
                ws_rf_we_q      <= ms_rf_we;
                ws_rf_waddr_q   <= ms_rf_waddr;
                ws_rf_wdata_q   <= ms_rf_wdata;
                ws_csr_we_q     <= ms_csr_we;
                ws_csr_num_q    <= ms_csr_num;
                ws_csr_wvalue_q <= ms_csr_wvalue;
                ws_csr_wmask_q  <= ms_csr_wmask;
            end
        end
    end

    assign commit_act = ws_valid_q && (state_q == RUN);
    assign take_int   = commit_act && has_int;
    assign take_exc   = commit_act && (has_int || ws_exc_q);
    assign take_ertn  = commit_act && !take_exc && ws_ertn_q;
    assign normal     = commit_act && !take_exc && !ws_ertn_q;

    assign wb_ex       = take_exc;
    assign ertn_flush  = take_ertn;
    assign wb_ecode    = take_int ? ECODE_INT : (take_exc ? ws_ecode_q : 6'h00);
    assign wb_esubcode = (take_exc && !take_int) ? ws_esubcode_q : 9'h000;
    assign wb_pc       = take_exc ? ws_pc_q : 32'h0;
    // The faulting address belongs only to a carried exception; an interrupt has none.
    assign wb_vaddr    = (take_exc && !take_int) ? ws_vaddr_q : 32'h0;

    assign rf_we      = normal && ws_rf_we_q;
    assign rf_waddr   = ws_rf_waddr_q;
    assign rf_wdata   = ws_rf_wdata_q;
    assign csr_we     = normal && ws_csr_we_q;
    assign csr_num    = ws_csr_num_q;
    assign csr_wvalue = ws_csr_wvalue_q;
    assign csr_wmask  = ws_csr_wmask_q;

    assign ws_epoch       = ws_epoch_q;
    assign redirect_valid = (state_q == REDIR);
    assign redirect_pc    = redirect_pc_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= RUN;
            ws_epoch_q    <= '0;
            redirect_pc_q <= '0;
        end else begin
            case (state_q)
                RUN: begin
                    if (take_exc) begin
                        state_q       <= REDIR;
                        redirect_pc_q <= csr_eentry;
                    end else if (take_ertn) begin
                        state_q       <= REDIR;
                        redirect_pc_q <= csr_era;
                    end
                end
                REDIR: begin
                    if (redirect_ready) begin
                        state_q    <= RUN;
                        ws_epoch_q <= ws_epoch_q + EPOCH_W'(1);
                    end
                end
                default: state_q <= RUN;
            endcase
        end
    end

`ifdef WB_DEBUG_TRACE_EN
    assign debug_wb_pc       = normal ? ws_pc_q : 32'h0;
    assign debug_wb_rf_we    = {4{rf_we}};
    assign debug_wb_rf_wnum  = rf_waddr;
    assign debug_wb_rf_wdata = rf_wdata;
`endif

endmodule

// File: tb/tb_wb_commit_unit.sv
// Bench for wb_commit_unit: directed scenarios plus random traffic against a cycle-level model.
module tb_wb_commit_unit;
    localparam int EW = 1;

    logic clk = 1'b0;
    logic reset;
    logic ms_to_ws_valid, ws_allow_in;
    logic [31:0] ms_pc, ms_vaddr, ms_rf_wdata, ms_csr_wvalue, ms_csr_wmask;
    logic ms_exc, ms_ertn, ms_rf_we, ms_csr_we;
    logic [5:0] ms_ecode;
    logic [8:0] ms_esubcode;
    logic [EW-1:0] ms_epoch;
    logic [4:0] ms_rf_waddr;
    logic [13:0] ms_csr_num;
    logic has_int, redirect_ready;
    logic [31:0] csr_eentry, csr_era;
    logic wb_ex, ertn_flush, csr_we, rf_we, redirect_valid;
    logic [5:0] wb_ecode;
    logic [8:0] wb_esubcode;
    logic [31:0] wb_pc, wb_vaddr, csr_wvalue, csr_wmask, rf_wdata, redirect_pc;
    logic [13:0] csr_num;
    logic [4:0] rf_waddr;
    logic [EW-1:0] ws_epoch;

    int total = 0;
    int bad = 0;

    wb_commit_unit #(.ECODE_INT(6'h00), .EPOCH_W(EW)) dut (
        .clk(clk), .reset(reset), .ms_to_ws_valid(ms_to_ws_valid), .ws_allow_in(ws_allow_in),
        .ms_pc(ms_pc), .ms_exc(ms_exc), .ms_ecode(ms_ecode), .ms_esubcode(ms_esubcode),
        .ms_vaddr(ms_vaddr), .ms_ertn(ms_ertn), .ms_epoch(ms_epoch),
        .ms_rf_we(ms_rf_we), .ms_rf_waddr(ms_rf_waddr), .ms_rf_wdata(ms_rf_wdata),
        .ms_csr_we(ms_csr_we), .ms_csr_num(ms_csr_num), .ms_csr_wvalue(ms_csr_wvalue),
        .ms_csr_wmask(ms_csr_wmask), .has_int(has_int), .csr_eentry(csr_eentry), .csr_era(csr_era),
        .wb_ex(wb_ex), .wb_ecode(wb_ecode), .wb_esubcode(wb_esubcode), .wb_pc(wb_pc),
        .wb_vaddr(wb_vaddr), .ertn_flush(ertn_flush), .csr_we(csr_we), .csr_num(csr_num),
        .csr_wvalue(csr_wvalue), .csr_wmask(csr_wmask), .rf_we(rf_we), .rf_waddr(rf_waddr),
        .rf_wdata(rf_wdata), .ws_epoch(ws_epoch), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .redirect_ready(redirect_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Model: the instruction sitting in WB, whether a redirect is outstanding, epoch, target.
    typedef struct {
        bit v; bit [31:0] pc; bit exc; bit [5:0] ecode; bit [8:0] esub; bit [31:0] vaddr;
        bit ertn; bit rf_we; bit [4:0] waddr; bit [31:0] wdata; bit csr_we;
    } slot_t;
    slot_t m_slot;
    bit m_redir;
    int m_epoch;
    bit [31:0] m_rpc;

    task automatic clear_in();
        ms_to_ws_valid = 0; ms_pc = 0; ms_exc = 0; ms_ecode = 0; ms_esubcode = 0;
        ms_vaddr = 0; ms_ertn = 0; ms_epoch = EW'(m_epoch); ms_rf_we = 0; ms_rf_waddr = 0;
        ms_rf_wdata = 0; ms_csr_we = 0; ms_csr_num = 0; ms_csr_wvalue = 0; ms_csr_wmask = 0;
        has_int = 0; redirect_ready = 0;
    endtask

    // Check the current cycle against the model, clock once, then advance the model.
    task automatic step();
        bit live, ex, is_int, ert, norm;
        #1;
        live   = m_slot.v && !m_redir;
        is_int = live && has_int;
        ex     = live && (has_int || m_slot.exc);
        ert    = live && !ex && m_slot.ertn;
        norm   = live && !ex && !m_slot.ertn;
        chk("allow_in", ws_allow_in, 1);
        chk("wb_ex", wb_ex, ex);
        chk("ertn_flush", ertn_flush, ert);
        chk("rf_we", rf_we, norm && m_slot.rf_we);
        chk("csr_we", csr_we, norm && m_slot.csr_we);
        chk("wb_pc", wb_pc, ex ? m_slot.pc : 0);
        chk("wb_ecode", wb_ecode, is_int ? 0 : (ex ? m_slot.ecode : 0));
        if (!is_int) chk("wb_vaddr", wb_vaddr, ex ? m_slot.vaddr : 0);
        if (norm && m_slot.rf_we) begin
            chk("rf_waddr", rf_waddr, m_slot.waddr);
            chk("rf_wdata", rf_wdata, m_slot.wdata);
        end
        chk("redirect_valid", redirect_valid, m_redir);
        if (m_redir) chk("redirect_pc", redirect_pc, m_rpc);
        chk("ws_epoch", ws_epoch, m_epoch);
        @(posedge clk);
        if (reset) begin
            m_redir = 0; m_epoch = 0; m_rpc = 0; m_slot.v = 0;
        end else begin
            bit old_redir = m_redir;
            int old_epoch = m_epoch;
            if (!m_redir) begin
                if (ex) begin m_redir = 1; m_rpc = csr_eentry; end
                else if (ert) begin m_redir = 1; m_rpc = csr_era; end
            end else if (redirect_ready) begin
                m_redir = 0; m_epoch = (m_epoch + 1) % (1 << EW);
            end
            m_slot.v = ms_to_ws_valid && !old_redir && (int'(ms_epoch) == old_epoch);
            if (ms_to_ws_valid) begin
                m_slot.pc = ms_pc; m_slot.exc = ms_exc; m_slot.ecode = ms_ecode;
                m_slot.esub = ms_esubcode; m_slot.vaddr = ms_vaddr; m_slot.ertn = ms_ertn;
                m_slot.rf_we = ms_rf_we; m_slot.waddr = ms_rf_waddr; m_slot.wdata = ms_rf_wdata;
                m_slot.csr_we = ms_csr_we;
            end
        end
        #1;
    endtask

    task automatic release_redir();
        clear_in(); redirect_ready = 1; step(); clear_in();
    endtask

    initial begin
        bit [31:0] held;
        int ep0;
        m_slot = '{default: 0}; m_redir = 0; m_epoch = 0; m_rpc = 0;
        csr_eentry = 32'h1c008000; csr_era = 32'h1c000040;
        clear_in();
        reset = 1; step(); step(); reset = 0;
        chk("rst_redirect_valid", redirect_valid, 0);
        chk("rst_redirect_pc", redirect_pc, 0);
        chk("rst_epoch", ws_epoch, 0);
        chk("rst_rf_we", rf_we, 0);
        chk("rst_wb_ex", wb_ex, 0);

        // Normal commit
        clear_in(); ms_to_ws_valid = 1; ms_pc = 32'h1c000000; ms_rf_we = 1;
        ms_rf_waddr = 5; ms_rf_wdata = 32'h1234; ms_epoch = 0;
        step(); clear_in(); #1;
        chk("t1_rf_we", rf_we, 1); chk("t1_waddr", rf_waddr, 5);
        chk("t1_wdata", rf_wdata, 32'h1234); chk("t1_wb_ex", wb_ex, 0);
        step();

        // Carried exception
        clear_in(); ms_to_ws_valid = 1; ms_pc = 32'h1c000010; ms_exc = 1; ms_ecode = 6'h08;
        ms_esubcode = 1; ms_vaddr = 3; ms_rf_we = 1;
        step(); clear_in(); #1;
        chk("t2_wb_ex", wb_ex, 1); chk("t2_ecode", wb_ecode, 6'h08);
        chk("t2_esub", wb_esubcode, 1); chk("t2_vaddr", wb_vaddr, 3); chk("t2_rf_we", rf_we, 0);
        step();
        chk("t2_rv", redirect_valid, 1); chk("t2_rpc", redirect_pc, 32'h1c008000);
        chk("t2_ex_pulse", wb_ex, 0);
        release_redir();
        chk("t2_epoch", ws_epoch, 1);

        // Stalled redirect with in-flight bundles
        clear_in(); ms_to_ws_valid = 1; ms_exc = 1; ms_ecode = 6'h09; ms_pc = 32'h1c000020;
        step(); clear_in(); step();
        held = redirect_pc; ep0 = m_epoch;
        for (int i = 0; i < 3; i++) begin
            clear_in(); ms_to_ws_valid = (i < 2); ms_rf_we = 1; ms_rf_waddr = 7; ms_rf_wdata = i;
            step();
            chk("t3_rf_we", rf_we, 0); chk("t3_rpc", redirect_pc, held);
        end
        release_redir();
        chk("t3_epoch", ws_epoch, (ep0 + 1) % 2);
        clear_in(); ms_to_ws_valid = 1; ms_rf_we = 1; ms_epoch = EW'(ep0); step();
        clear_in(); #1; chk("t3_stale_drop", rf_we, 0);
        step();

        // Interrupt beats a CSR write
        clear_in(); ms_to_ws_valid = 1; ms_csr_we = 1; ms_csr_num = 14'h30; ms_pc = 32'h1c000030;
        step(); clear_in(); has_int = 1; #1;
        chk("t4_wb_ex", wb_ex, 1); chk("t4_ecode", wb_ecode, 0);
        chk("t4_csr_we", csr_we, 0); chk("t4_pc", wb_pc, 32'h1c000030);
        step(); release_redir();

        // ertn
        clear_in(); ms_to_ws_valid = 1; ms_ertn = 1; step(); clear_in(); #1;
        chk("t5_ertn", ertn_flush, 1); chk("t5_wb_ex", wb_ex, 0);
        step();
        chk("t5_ertn_pulse", ertn_flush, 0); chk("t5_rpc", redirect_pc, 32'h1c000040);
        release_redir();

        // Reset in REDIR
        clear_in(); ms_to_ws_valid = 1; ms_exc = 1; step(); clear_in(); step();
        chk("t6_in_redir", redirect_valid, 1);
        reset = 1; step(); reset = 0; clear_in();
        chk("t6_rv", redirect_valid, 0); chk("t6_epoch", ws_epoch, 0);
        ms_to_ws_valid = 1; ms_rf_we = 1; ms_rf_waddr = 9; ms_rf_wdata = 32'hbeef; ms_epoch = 0;
        step(); clear_in(); #1;
        chk("t6_rf_we", rf_we, 1); chk("t6_wdata", rf_wdata, 32'hbeef);
        step();

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            ms_to_ws_valid = ($urandom_range(0, 3) != 0);
            ms_pc = $urandom; ms_vaddr = $urandom; ms_rf_wdata = $urandom;
            ms_exc = ($urandom_range(0, 9) == 0); ms_ertn = ($urandom_range(0, 9) == 0);
            ms_ecode = 6'($urandom); ms_esubcode = 9'($urandom);
            ms_epoch = ($urandom_range(0, 5) == 0) ? EW'($urandom) : EW'(m_epoch);
            ms_rf_we = 1'($urandom); ms_rf_waddr = 5'($urandom);
            ms_csr_we = 1'($urandom); ms_csr_num = 14'($urandom);
            has_int = ($urandom_range(0, 15) == 0);
            redirect_ready = ($urandom_range(0, 2) == 0);
            csr_eentry = $urandom; csr_era = $urandom;
            reset = ($urandom_range(0, 99) == 0);
            step();
        end
        reset = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
